// File: rtl/instruction_assembler_pkg.sv
// Shared definitions for the MCS-51 instruction assembler.
// Provides the instruction-size enum, the opcode-length lookup function and a
// handful of named opcodes that show up in directed tests.
package instruction_assembler_pkg;

    typedef enum logic [1:0] {
        SIZE_1 = 2'd1,
        SIZE_2 = 2'd2,
        SIZE_3 = 2'd3
    } instr_size_e;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_LJMP      = 8'h02;
    localparam logic [7:0] OP_ACALL     = 8'h11;
    localparam logic [7:0] OP_MOV_A_IMM = 8'h74;
    localparam logic [7:0] OP_MOV_DPTR  = 8'h90;
    localparam logic [7:0] OP_RESERVED  = 8'hA5;
    localparam logic [7:0] OP_CJNE_IMM  = 8'hB4;
    localparam logic [7:0] OP_MOV_A_DIR = 8'hE5;

    // Total instruction length in bytes, from the standard MCS-51 opcode map.
    function automatic instr_size_e opcode_size(input logic [7:0] opcode);
        instr_size_e size;
        size = SIZE_1;
        // AJMP/ACALL occupy every opcode with low nibble 1
        if (opcode[3:0] == 4'h1) begin
            size = SIZE_2;
        end else if (opcode inside {
                8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42, 8'h44, 8'h45,
                8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72,
                8'h74, 8'h76, 8'h77, [8'h78:8'h7F], 8'h80, 8'h82, 8'h86, 8'h87,
                [8'h88:8'h8F], 8'h92, 8'h94, 8'h95, 8'hA0, 8'hA2, 8'hA6, 8'hA7,
                [8'hA8:8'hAF], 8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2,
                [8'hD8:8'hDF], 8'hE5, 8'hF5}) begin
            size = SIZE_2;
        end
        if (opcode inside {8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
                           8'h75, 8'h85, 8'h90, [8'hB4:8'hBF], 8'hD5}) begin
            size = SIZE_3;
        end
        return size;
    endfunction

endpackage

// File: rtl/instruction_assembler_byte_queue.sv
// Circular byte queue between the fetch beat and the instruction slot.
// Ports:
//   i_clk     - core clock
//   i_clear   - synchronous empty (reset or redirect)
//   i_push    - write one beat; its lowest i_skip bytes are dropped
//   i_data    - fetch beat, byte k in bits [8k+7:8k]
//   i_skip    - number of leading beat bytes to drop
//   i_pop     - remove i_pop_n bytes from the head
//   i_pop_n   - 1..3 bytes to pop
//   o_peek0-2 - head byte and the two following bytes
//   o_count   - bytes currently held
module instruction_assembler_byte_queue #(
    parameter int unsigned FETCH_BYTES = 2,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned SKIP_WIDTH  = 1
) (
    input  logic                           i_clk,
    input  logic                           i_clear,
    input  logic                           i_push,
    input  logic [8*FETCH_BYTES-1:0]       i_data,
    input  logic [SKIP_WIDTH-1:0]          i_skip,
    input  logic                           i_pop,
    input  logic [1:0]                     i_pop_n,
    output logic [7:0]                     o_peek0,
    output logic [7:0]                     o_peek1,
    output logic [7:0]                     o_peek2,
    output logic [$clog2(QUEUE_DEPTH):0]   o_count
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      r_mem [QUEUE_DEPTH];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;
    logic [CntW-1:0] w_wr_n;
    logic [CntW-1:0] w_pop_n;

    always_comb begin
        w_wr_n  = i_push ? (CntW'(FETCH_BYTES) - CntW'(i_skip)) : '0;
        w_pop_n = i_pop ? CntW'(i_pop_n) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                // Surviving bytes are packed down so the first kept byte lands at wr_ptr
                for (int k = 0; k < FETCH_BYTES; k++) begin
                    if (k >= int'(i_skip)) begin
                        r_mem[r_wr_ptr + PtrW'(k) - PtrW'(i_skip)] <= i_data[8*k +: 8];
                    end
                end
                r_wr_ptr <= r_wr_ptr + PtrW'(w_wr_n);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(i_pop_n);
            end
            r_count <= r_count + w_wr_n - w_pop_n;
        end
    end

    assign o_peek0 = r_mem[r_rd_ptr];
    assign o_peek1 = r_mem[r_rd_ptr + PtrW'(1)];
    assign o_peek2 = r_mem[r_rd_ptr + PtrW'(2)];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_assembler.sv
// MCS-51 instruction assembler: buffers code-memory fetch beats and presents
// whole instructions (opcode, operands, size, address) in a valid/ready slot.
// Ports:
//   i_clk, i_reset    - clock, synchronous active-high reset
//   i_fetch_*         - fetch beat input; o_fetch_ready when a full beat fits
//   i_flush, i_flush_pc - redirect to a new (possibly unaligned) address
//   o_instr_*         - output slot; i_instr_ready consumes it
//   o_queue_count     - bytes buffered behind the slot
module instruction_assembler
    import instruction_assembler_pkg::*;
#(
    parameter int unsigned FETCH_BYTES = 2,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [8*FETCH_BYTES-1:0]     i_fetch_data,
    input  logic                         i_fetch_valid,
    output logic                         o_fetch_ready,
    input  logic                         i_flush,
    input  logic [ADDR_WIDTH-1:0]        i_flush_pc,
    output logic                         o_instr_valid,
    input  logic                         i_instr_ready,
    output logic [7:0]                   o_instr_opcode,
    output logic [7:0]                   o_instr_operand1,
    output logic [7:0]                   o_instr_operand2,
    output logic [1:0]                   o_instr_size,
    output logic [ADDR_WIDTH-1:0]        o_instr_pc,
    output logic [$clog2(QUEUE_DEPTH):0] o_queue_count
);

    localparam int unsigned CntW  = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned SkipW = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;

    logic [CntW-1:0]       w_count;
    logic [7:0]            w_peek0;
    logic [7:0]            w_peek1;
    logic [7:0]            w_peek2;
    instr_size_e           w_head_size;
    logic                  w_clear;
    logic                  w_push;
    logic                  w_load;

    logic [SkipW-1:0]      r_align_skip;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_valid;
    logic [7:0]            r_opcode;
    logic [7:0]            r_operand1;
    logic [7:0]            r_operand2;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_instr_pc;

    assign w_head_size   = opcode_size(w_peek0);
    assign o_fetch_ready = (CntW'(QUEUE_DEPTH) - w_count) >= CntW'(FETCH_BYTES);
    assign w_clear       = i_reset | i_flush;
    assign w_push        = i_fetch_valid & o_fetch_ready & ~w_clear;
    // Head size is at least 1, so an empty queue never loads
    assign w_load        = ~w_clear & (~r_valid | i_instr_ready)
                         & (w_count >= CntW'(w_head_size));

    instruction_assembler_byte_queue #(
        .FETCH_BYTES (FETCH_BYTES),
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .SKIP_WIDTH  (SkipW)
    ) u_byte_queue (
        .i_clk   (i_clk),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_data  (i_fetch_data),
        .i_skip  (r_align_skip),
        .i_pop   (w_load),
        .i_pop_n (w_head_size),
        .o_peek0 (w_peek0),
        .o_peek1 (w_peek1),
        .o_peek2 (w_peek2),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc         <= '0;
            r_align_skip <= '0;
            r_valid      <= 1'b0;
            r_opcode     <= '0;
            r_operand1   <= '0;
            r_operand2   <= '0;
            r_size       <= '0;
            r_instr_pc   <= '0;
        end else if (i_flush) begin
            r_pc         <= i_flush_pc;
            // Bytes of the first beat below the target address are not code
            r_align_skip <= SkipW'(i_flush_pc & ADDR_WIDTH'(FETCH_BYTES - 1));
            r_valid      <= 1'b0;
        end else begin
            if (w_push) begin
                r_align_skip <= '0;
            end
            if (w_load) begin
                r_valid    <= 1'b1;
                r_opcode   <= w_peek0;
                r_operand1 <= (w_head_size >= SIZE_2) ? w_peek1 : 8'h00;
                r_operand2 <= (w_head_size == SIZE_3) ? w_peek2 : 8'h00;
                r_size     <= w_head_size;
                r_instr_pc <= r_pc;
                r_pc       <= r_pc + ADDR_WIDTH'(w_head_size);
            end else if (i_instr_ready) begin
                // Consumed with nothing complete behind it
                r_valid <= 1'b0;
            end
        end
    end

    assign o_instr_valid    = r_valid;
    assign o_instr_opcode   = r_opcode;
    assign o_instr_operand1 = r_operand1;
    assign o_instr_operand2 = r_operand2;
    assign o_instr_size     = r_size;
    assign o_instr_pc       = r_instr_pc;
    assign o_queue_count    = w_count;

endmodule

// File: tb/tb_instruction_assembler.sv
// Self-checking bench for instruction_assembler: directed tables, hand-written
// corner sequences and randomized traffic against a byte-queue reference model.
module tb_instruction_assembler;
    import instruction_assembler_pkg::*;

    localparam int FB    = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, fetch_valid, flush, instr_ready;
    logic [15:0] fetch_data, flush_pc;
    logic        fetch_ready, instr_valid;
    logic [7:0]  opcode, operand1, operand2;
    logic [1:0]  size;
    logic [15:0] ipc;
    logic [3:0]  qcount;

    logic        r4, fv4, fl4, ir4, fr4, iv4;
    logic [31:0] fd4;
    logic [15:0] fpc4, pc4;
    logic [7:0]  op4, a4, b4;
    logic [1:0]  sz4;
    logic [3:0]  qc4;

    instruction_assembler #(.FETCH_BYTES(FB), .QUEUE_DEPTH(DEPTH), .ADDR_WIDTH(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_fetch_data(fetch_data), .i_fetch_valid(fetch_valid),
        .o_fetch_ready(fetch_ready), .i_flush(flush), .i_flush_pc(flush_pc),
        .o_instr_valid(instr_valid), .i_instr_ready(instr_ready), .o_instr_opcode(opcode),
        .o_instr_operand1(operand1), .o_instr_operand2(operand2), .o_instr_size(size),
        .o_instr_pc(ipc), .o_queue_count(qcount)
    );

    instruction_assembler #(.FETCH_BYTES(4), .QUEUE_DEPTH(8), .ADDR_WIDTH(16)) dut4 (
        .i_clk(clk), .i_reset(r4), .i_fetch_data(fd4), .i_fetch_valid(fv4),
        .o_fetch_ready(fr4), .i_flush(fl4), .i_flush_pc(fpc4),
        .o_instr_valid(iv4), .i_instr_ready(ir4), .o_instr_opcode(op4),
        .o_instr_operand1(a4), .o_instr_operand2(b4), .o_instr_size(sz4),
        .o_instr_pc(pc4), .o_queue_count(qc4)
    );

    typedef struct {
        logic [7:0] op, o1, o2;
        int         size;
        int         pc;
    } instr_t;

    int          total = 0;
    int          bad   = 0;
    int unsigned sz_tab [256];
    logic [7:0]  mq[$];
    logic [7:0]  src[$];
    instr_t      got[$];
    instr_t      tab [24];
    bit          m_valid;
    logic [7:0]  m_op, m_o1, m_o2;
    int          m_size, m_ipc, m_pc, m_skip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic init_sizes();
        logic [7:0] three[$] = '{8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
                                 8'h75, 8'h85, 8'h90, 8'hD5};
        logic [7:0] two[$] = '{8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42,
                               8'h44, 8'h45, 8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62,
                               8'h64, 8'h65, 8'h70, 8'h72, 8'h74, 8'h76, 8'h77, 8'h80,
                               8'h82, 8'h86, 8'h87, 8'h92, 8'h94, 8'h95, 8'hA0, 8'hA2,
                               8'hA6, 8'hA7, 8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0,
                               8'hD2, 8'hE5, 8'hF5};
        for (int i = 0; i < 256; i++) sz_tab[i] = ((i % 16) == 1) ? 2 : 1;
        foreach (two[i]) sz_tab[two[i]] = 2;
        for (int i = 0; i < 8; i++) begin
            sz_tab[8'h78 + i] = 2;
            sz_tab[8'h88 + i] = 2;
            sz_tab[8'hA8 + i] = 2;
            sz_tab[8'hD8 + i] = 2;
        end
        for (int i = 8'hB4; i <= 8'hBF; i++) sz_tab[i] = 3;
        foreach (three[i]) sz_tab[three[i]] = 3;
    endtask

    task automatic init_table();
        tab[0]  = '{8'h74, 8'h55, 8'h00, 2, 'h0000};
        tab[1]  = '{8'h02, 8'h12, 8'h34, 3, 'h0002};
        tab[2]  = '{8'h00, 8'h00, 8'h00, 1, 'h0005};
        tab[3]  = '{8'hA5, 8'h00, 8'h00, 1, 'h0000};
        tab[4]  = '{8'hB4, 8'h01, 8'h02, 3, 'h0001};
        tab[5]  = '{8'h11, 8'h33, 8'h00, 2, 'h0004};
        tab[6]  = '{8'h00, 8'h00, 8'h00, 1, 'h0006};
        tab[7]  = '{8'h74, 8'h5A, 8'h00, 2, 'h0007};
        tab[8]  = '{8'h02, 8'h12, 8'h34, 3, 'h0009};
        tab[9]  = '{8'hE5, 8'h10, 8'h00, 2, 'h000C};
        tab[10] = '{8'h90, 8'hAB, 8'hCD, 3, 'h000E};
        tab[11] = '{8'hD8, 8'hFE, 8'h00, 2, 'h0011};
        tab[12] = '{8'h85, 8'h01, 8'h02, 3, 'h0013};
        tab[13] = '{8'hF1, 8'h20, 8'h00, 2, 'h0016};
        tab[14] = '{8'h43, 8'h0F, 8'h80, 3, 'h0018};
        tab[15] = '{8'hA3, 8'h00, 8'h00, 1, 'h001B};
        for (int i = 0; i < 7; i++) tab[16 + i] = '{8'h00, 8'h00, 8'h00, 1, i};
        tab[23] = '{8'h90, 8'h12, 8'h34, 3, 'h0007};
    endtask

    // One clock: drive a beat from src if asked, advance the model, compare after the edge.
    task automatic cycle(input bit use_src);
        bit from_src, acc;
        int s;
        from_src = use_src && (src.size() >= FB);
        if (from_src) begin
            fetch_valid = 1'b1;
            fetch_data  = {src[1], src[0]};
        end else begin
            fetch_valid = 1'b0;
            fetch_data  = 16'($urandom);
        end
        if (instr_valid === 1'b1 && instr_ready)
            got.push_back('{opcode, operand1, operand2, int'(size), int'(ipc)});
        acc = 1'b0;
        if (reset) begin
            mq.delete();
            m_valid = 1'b0;
            m_pc = 0;
            m_skip = 0;
        end else if (flush) begin
            mq.delete();
            m_valid = 1'b0;
            m_pc = int'(flush_pc);
            m_skip = int'(flush_pc) % FB;
        end else begin
            acc = from_src && ((DEPTH - mq.size()) >= FB);
            s = (mq.size() > 0) ? int'(sz_tab[mq[0]]) : 4;
            if ((!m_valid || instr_ready) && mq.size() >= s) begin
                m_op   = mq.pop_front();
                m_o1   = (s >= 2) ? mq.pop_front() : 8'h00;
                m_o2   = (s >= 3) ? mq.pop_front() : 8'h00;
                m_size = s;
                m_ipc  = m_pc;
                m_pc   = (m_pc + s) % 65536;
                m_valid = 1'b1;
            end else if (instr_ready) begin
                m_valid = 1'b0;
            end
            if (acc) begin
                for (int k = m_skip; k < FB; k++) mq.push_back(fetch_data[8*k +: 8]);
                m_skip = 0;
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            void'(src.pop_front());
            void'(src.pop_front());
        end
        check("valid", 32'(instr_valid), 32'(m_valid));
        check("queue_count", 32'(qcount), mq.size());
        check("fetch_ready", 32'(fetch_ready), 32'((DEPTH - mq.size()) >= FB));
        if (m_valid) begin
            check("opcode", 32'(opcode), 32'(m_op));
            check("operand1", 32'(operand1), 32'(m_o1));
            check("operand2", 32'(operand2), 32'(m_o2));
            check("size", 32'(size), m_size);
            check("pc", 32'(ipc), m_ipc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(0);
        reset = 1'b0;
        got.delete();
        src.delete();
    endtask

    task automatic run_table(input int first, input int n);
        do_reset();
        for (int i = first; i < first + n; i++) begin
            src.push_back(tab[i].op);
            if (tab[i].size >= 2) src.push_back(tab[i].o1);
            if (tab[i].size >= 3) src.push_back(tab[i].o2);
        end
        if (src.size() % 2 != 0) src.push_back(8'h00);
        instr_ready = 1'b1;
        for (int c = 0; c < 60 && got.size() < n; c++) cycle(1);
        check("table_count", got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            check("tab_opcode", 32'(got[i].op), 32'(tab[first + i].op));
            check("tab_operand1", 32'(got[i].o1), 32'(tab[first + i].o1));
            check("tab_operand2", 32'(got[i].o2), 32'(tab[first + i].o2));
            check("tab_size", got[i].size, tab[first + i].size);
            check("tab_pc", got[i].pc, tab[first + i].pc);
        end
    endtask

    initial begin
        logic [7:0]  h_op, h_o1, h_o2;
        logic [1:0]  h_sz;
        logic [15:0] h_pc;
        bit          saw, stable;
        int          n, bytes;

        init_sizes();
        init_table();
        reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
        flush_pc = '0; instr_ready = 1'b0;
        r4 = 1'b1; fv4 = 1'b0; fl4 = 1'b0; ir4 = 1'b1; fd4 = '0; fpc4 = '0;

        // Four-byte fetch build: unaligned redirect drops leading beat bytes
        @(posedge clk); #1;
        r4 = 1'b0;
        check("fb4_reset_ready", 32'(fr4), 1);
        check("fb4_reset_count", 32'(qc4), 0);
        fv4 = 1'b1; fd4 = {8'h00, 8'h00, 8'h55, 8'h74};
        @(posedge clk); #1;
        fl4 = 1'b1; fpc4 = 16'h0103; fd4 = 32'hDEADBEEF;
        @(posedge clk); #1;
        fl4 = 1'b0;
        check("fb4_flush_invalid", 32'(iv4), 0);
        check("fb4_flush_count", 32'(qc4), 0);
        fd4 = {8'hE5, 8'h22, 8'h11, 8'h00};
        @(posedge clk); #1;
        check("fb4_skip_count", 32'(qc4), 1);
        fd4 = {8'h00, 8'h00, 8'h00, 8'h12};
        @(posedge clk); #1;
        fv4 = 1'b0;
        @(posedge clk); #1;
        check("fb4_valid", 32'(iv4), 1);
        check("fb4_opcode", 32'(op4), 32'hE5);
        check("fb4_operand1", 32'(a4), 32'h12);
        check("fb4_operand2", 32'(b4), 0);
        check("fb4_size", 32'(sz4), 2);
        check("fb4_pc", 32'(pc4), 32'h0103);

        // Reset state
        do_reset();
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_count", 32'(qcount), 0);
        check("rst_fetch_ready", 32'(fetch_ready), 1);
        check("rst_data", {opcode, operand1, operand2, 6'd0, size}, 0);
        check("rst_pc", 32'(ipc), 0);

        run_table(0, 3);
        run_table(3, 13);
        run_table(16, 8);

        // Backpressure: slot held while beats keep arriving
        do_reset();
        for (int i = 0; i < 24; i++) src.push_back(8'($urandom));
        instr_ready = 1'b0;
        n = 0;
        while (instr_valid !== 1'b1 && n < 10) begin
            cycle(1);
            n++;
        end
        check("bp_slot_filled", 32'(instr_valid), 1);
        h_op = opcode; h_o1 = operand1; h_o2 = operand2; h_sz = size; h_pc = ipc;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1);
            stable = (opcode === h_op) && (operand1 === h_o1) && (operand2 === h_o2)
                  && (size === h_sz) && (ipc === h_pc) && (instr_valid === 1'b1);
            check("bp_hold_stable", 32'(stable), 1);
            check("bp_count_bound", 32'(qcount <= 4'd8), 1);
            if (fetch_ready === 1'b0) saw = 1'b1;
        end
        check("bp_fetch_ready_dropped", 32'(saw), 1);
        instr_ready = 1'b1;
        for (int i = 0; i < 30; i++) cycle(1);
        bytes = int'(qcount) + ((instr_valid === 1'b1) ? int'(size) : 0);
        foreach (got[i]) bytes += got[i].size;
        check("bp_bytes_delivered", bytes, 24);

        // Flush mid-stream with a beat in the same cycle
        do_reset();
        src = '{8'h74, 8'h55, 8'h02, 8'h12, 8'h34, 8'h00, 8'h74, 8'h55, 8'h66, 8'h77};
        instr_ready = 1'b1;
        repeat (3) cycle(1);
        flush = 1'b1; flush_pc = 16'h0103;
        cycle(1);
        flush = 1'b0;
        check("flush_invalid", 32'(instr_valid), 0);
        check("flush_count", 32'(qcount), 0);
        src = '{8'h22, 8'hE5, 8'h12, 8'h00};
        got.delete();
        for (int c = 0; c < 10 && got.size() == 0; c++) cycle(1);
        check("flush_first_op", (got.size() > 0) ? 32'(got[0].op) : 32'hFFFF_FFFF, 32'hE5);
        check("flush_first_o1", (got.size() > 0) ? 32'(got[0].o1) : 32'hFFFF_FFFF, 32'h12);
        check("flush_first_pc", (got.size() > 0) ? got[0].pc : -1, 32'h0103);

        // Reset while an instruction is held and five bytes are queued
        do_reset();
        flush = 1'b1; flush_pc = 16'h0001;
        cycle(0);
        flush = 1'b0;
        src = '{8'h99, 8'h74, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        instr_ready = 1'b0;
        n = 0;
        while (!(instr_valid === 1'b1 && qcount == 4'd5) && n < 20) begin
            cycle(1);
            n++;
        end
        check("midrst_precondition", 32'(instr_valid === 1'b1 && qcount == 4'd5), 1);
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        check("midrst_valid", 32'(instr_valid), 0);
        check("midrst_count", 32'(qcount), 0);
        check("midrst_fetch_ready", 32'(fetch_ready), 1);
        src = '{8'hA5, 8'h00};
        got.delete();
        instr_ready = 1'b1;
        for (int c = 0; c < 10 && got.size() == 0; c++) cycle(1);
        check("midrst_next_op", (got.size() > 0) ? 32'(got[0].op) : 32'hFFFF_FFFF, 32'hA5);
        check("midrst_next_pc", (got.size() > 0) ? got[0].pc : -1, 0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            reset = ($urandom_range(0, 299) == 0);
            flush = !reset && ($urandom_range(0, 79) == 0);
            flush_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2))
                                                   : 16'($urandom);
            while (src.size() < 4) src.push_back(8'($urandom));
            cycle($urandom_range(0, 3) != 0);
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
